hazard_controller: RTL and testbench
====================================

Name: hazard_controller

Overview:
- Central pipeline sequencer for the fetch/decode/execute front end.
- Generates the stall and flush controls consumed by the fetch and decode stage registers and the EX stage register.
- Detects load-use hazards on the decode stage's rs1/rs2, holds the pipe while the multi-cycle divider runs, and sequences trap entry: drain, then one redirect cycle.
- Sits beside the decode stage and sees the decoded register indices, EX-stage destination info and memory-stage exception status.

Parameters:
- DRAIN_CYCLES, 2, cycles spent in TRAP_DRAIN before trap redirect (range 1..15).
- DIV_MAX_CYCLES, 34, divider watchdog limit in cycles; on expiry, report a timeout and release the pipe.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst_n  in  1  synchronous active-low reset.
- i_de_valid  in  1  decode stage holds a valid instruction.
- i_de_rs1  in  5  decode rs1 index (rv32_register).
- i_de_rs2  in  5  decode rs2 index (rv32_register).
- i_de_uses_rs1  in  1  decode instruction reads rs1.
- i_de_uses_rs2  in  1  decode instruction reads rs2.
- i_ex_valid  in  1  EX stage holds a valid instruction.
- i_ex_rd  in  5  EX destination register.
- i_ex_is_load  in  1  EX instruction is a load.
- i_ex_div_start  in  1  valid div/rem entering the divider this cycle.
- i_div_done  in  1  divider result ready (1-cycle pulse).
- i_ex_redirect  in  1  taken branch/jump resolved in EX.
- i_ma_exc  in  1  exception committed in the memory stage (any de_error/fe_error/misalign).
- o_fe_stall  out  1  hold the fetch stage.
- o_de_stall  out  1  hold the decode stage register (decode i_stall).
- o_ex_stall  out  1  hold the EX register.
- o_fe_flush  out  1  invalidate fetch output.
- o_de_flush  out  1  invalidate decode (decode i_flush).
- o_ex_flush  out  1  insert a bubble into EX.
- o_div_kill  out  1  abort the divider (1-cycle pulse).
- o_div_timeout  out  1  watchdog expired (1-cycle pulse).
- o_trap_take  out  1  redirect fetch to the trap vector (1-cycle pulse).

Behaviour:
- States: RUN, DIV_BUSY, TRAP_DRAIN, TRAP_TAKE.
- Two counters:
  - div_cnt, 6 bits.
  - drain_cnt, 4 bits.
- Outputs are combinational from state, counters and inputs; no added latency.
- Reset (i_rst_n=0 at the edge):
  - Next state is RUN and both counters clear.
  - While i_rst_n=0: all stalls=0, o_fe_flush=o_de_flush=o_ex_flush=1, o_div_kill=o_div_timeout=o_trap_take=0.
  - Reset mid-division or mid-drain aborts cleanly; o_div_kill is not pulsed.
- Load-use hazard, defined as load_use =
  - i_de_valid && i_ex_valid && i_ex_is_load && i_ex_rd!=0,
  - && ((i_de_uses_rs1 && i_de_rs1==i_ex_rd) || (i_de_uses_rs2 && i_de_rs2==i_ex_rd)).
- RUN, priority highest first:
  1. i_ma_exc: all flushes=1, stalls=0, o_div_kill=1 if i_ex_div_start. Next state TRAP_DRAIN, drain_cnt=0.
  2. i_ex_redirect: fe/de flush=1, all stalls=0; this suppresses load-use in the same cycle.
  3. i_ex_div_start: fe/de/ex stall=1. Next state DIV_BUSY, div_cnt=1.
  4. load_use: fe/de stall=1, ex_flush=1 for exactly one cycle. The hazard clears when the load leaves EX.
  5. Otherwise all outputs are 0.
- DIV_BUSY:
  - fe/de/ex stall=1; div_cnt increments each cycle.
  - i_ma_exc: o_div_kill=1 and all flushes=1. Next state TRAP_DRAIN. Takes priority over i_div_done in the same cycle.
  - Else i_div_done: stalls drop this same cycle. Next state RUN.
  - Else div_cnt==DIV_MAX_CYCLES: o_div_timeout=1, o_div_kill=1, stalls drop. Next state RUN.
- TRAP_DRAIN:
  - All flushes=1, stalls=0; drain_cnt increments each cycle.
  - When drain_cnt==DRAIN_CYCLES-1, next state is TRAP_TAKE.
  - i_ex_redirect, i_ex_div_start and i_ma_exc are ignored.
- TRAP_TAKE:
  - o_trap_take=1 and all flushes=1 for one cycle. Next state RUN.
  - A new i_ma_exc arriving this cycle re-enters TRAP_DRAIN instead of RUN; o_trap_take is still 1.
- Counters saturate; they never wrap.

Decomposition:
- Shared types package:
  - typedef hazard_state_e {RUN, DIV_BUSY, TRAP_DRAIN, TRAP_TAKE}.
  - struct pipe_ctrl_t {fe_stall, de_stall, ex_stall, fe_flush, de_flush, ex_flush}.
  - Reuse rv32_register for the 5-bit indices.
- Sub-module: load_use_detect, purely combinational, producing the load_use term; the FSM stays in hazard_controller.

Test Plan:
- Load-use: EX lw rd=5, DE add rs1=5 uses_rs1=1 -> one cycle of fe/de stall=1, ex_flush=1. Next cycle (i_ex_is_load=0) all outputs 0. Repeat with rd=0 -> no stall.
- Redirect + load-use in the same cycle: i_ex_redirect=1 with a matching hazard -> fe/de flush=1, stalls=0, ex_flush=0.
- Divide: i_ex_div_start, i_div_done after 10 cycles -> stalls=1 for 11 cycles, then RUN. Variant with no done -> o_div_timeout and o_div_kill pulse at cycle 34, then RUN.
- Exception during divide: i_ma_exc at cycle 5 of DIV_BUSY -> o_div_kill=1, 2 drain cycles of flushes, o_trap_take pulse on cycle 3, then RUN.
- Back-to-back trap: i_ma_exc asserted in TRAP_TAKE -> o_trap_take=1, return to TRAP_DRAIN, second o_trap_take after DRAIN_CYCLES more cycles.
- Reset mid-drain: i_rst_n=0 for 1 cycle in TRAP_DRAIN -> flushes=1 during reset, state RUN after, no o_trap_take.

Source files
------------

// File: rtl/hazard_controller_pkg.sv
// Shared types for the front-end hazard controller: FSM state, register index
// and the bundle of stage stall/flush controls.
package hazard_controller_pkg;

    typedef logic [4:0] rv32_register;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        DIV_BUSY   = 2'd1,
        TRAP_DRAIN = 2'd2,
        TRAP_TAKE  = 2'd3
    } hazard_state_e;

    typedef struct packed {
        logic fe_stall;
        logic de_stall;
        logic ex_stall;
        logic fe_flush;
        logic de_flush;
        logic ex_flush;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_NONE      = '{default: 1'b0};
    localparam pipe_ctrl_t CTRL_FLUSH_ALL = '{fe_flush: 1'b1, de_flush: 1'b1,
                                              ex_flush: 1'b1, default: 1'b0};
    localparam pipe_ctrl_t CTRL_STALL_ALL = '{fe_stall: 1'b1, de_stall: 1'b1,
                                              ex_stall: 1'b1, default: 1'b0};

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use detector: decode reads a register that the load
// currently in EX has not yet written.
module load_use_detect
    import hazard_controller_pkg::*;
(
    input  logic         de_valid,
    input  rv32_register de_rs1,
    input  rv32_register de_rs2,
    input  logic         de_uses_rs1,
    input  logic         de_uses_rs2,
    input  logic         ex_valid,
    input  rv32_register ex_rd,
    input  logic         ex_is_load,
    output logic         load_use
);

    rv32_register src_idx [2];
    logic [1:0]   src_used;
    logic [1:0]   src_hit;

    assign src_idx[0] = de_rs1;
    assign src_idx[1] = de_rs2;
    assign src_used   = {de_uses_rs2, de_uses_rs1};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign src_hit[gi] = src_used[gi] && (src_idx[gi] == ex_rd);
        end
    endgenerate

    // x0 is never a real dependency, so a load to x0 never stalls.
    assign load_use = de_valid && ex_valid && ex_is_load &&
                      (ex_rd != 5'd0) && (|src_hit);

endmodule

// File: rtl/hazard_controller.sv
// Front-end pipeline sequencer: load-use stalls, divider hold with watchdog,
// and trap entry (drain, then a single redirect cycle).
module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int DRAIN_CYCLES   = 2,
    parameter int DIV_MAX_CYCLES = 34
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_de_valid,
    input  rv32_register i_de_rs1,
    input  rv32_register i_de_rs2,
    input  logic         i_de_uses_rs1,
    input  logic         i_de_uses_rs2,
    input  logic         i_ex_valid,
    input  rv32_register i_ex_rd,
    input  logic         i_ex_is_load,
    input  logic         i_ex_div_start,
    input  logic         i_div_done,
    input  logic         i_ex_redirect,
    input  logic         i_ma_exc,
    output logic         o_fe_stall,
    output logic         o_de_stall,
    output logic         o_ex_stall,
    output logic         o_fe_flush,
    output logic         o_de_flush,
    output logic         o_ex_flush,
    output logic         o_div_kill,
    output logic         o_div_timeout,
    output logic         o_trap_take
);

    localparam logic [5:0] DIV_LIMIT  = 6'(DIV_MAX_CYCLES);
    localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

    hazard_state_e state_reg, state_next;
    logic [5:0]    div_cnt_reg, div_cnt_next;
    logic [3:0]    drain_cnt_reg, drain_cnt_next;
    pipe_ctrl_t    ctrl;
    logic          div_kill, div_timeout, trap_take;
    logic          load_use;

    load_use_detect u_load_use_detect (
        .de_valid    (i_de_valid),
        .de_rs1      (i_de_rs1),
        .de_rs2      (i_de_rs2),
        .de_uses_rs1 (i_de_uses_rs1),
        .de_uses_rs2 (i_de_uses_rs2),
        .ex_valid    (i_ex_valid),
        .ex_rd       (i_ex_rd),
        .ex_is_load  (i_ex_is_load),
        .load_use    (load_use)
    );

    always_comb begin
        state_next     = state_reg;
        div_cnt_next   = div_cnt_reg;
        drain_cnt_next = drain_cnt_reg;
        ctrl           = CTRL_NONE;
        div_kill       = 1'b0;
        div_timeout    = 1'b0;
        trap_take      = 1'b0;

        case (state_reg)
            RUN: begin
                if (i_ma_exc) begin
                    ctrl           = CTRL_FLUSH_ALL;
                    div_kill       = i_ex_div_start;
                    state_next     = TRAP_DRAIN;
                    drain_cnt_next = 4'd0;
                end else if (i_ex_redirect) begin
                    ctrl.fe_flush = 1'b1;
                    ctrl.de_flush = 1'b1;
                end else if (i_ex_div_start) begin
                    ctrl         = CTRL_STALL_ALL;
                    state_next   = DIV_BUSY;
                    div_cnt_next = 6'd1;
                end else if (load_use) begin
                    ctrl.fe_stall = 1'b1;
                    ctrl.de_stall = 1'b1;
                    ctrl.ex_flush = 1'b1;
                end
            end
            DIV_BUSY: begin
                div_cnt_next = (div_cnt_reg == 6'h3f) ? div_cnt_reg : div_cnt_reg + 6'd1;
                // Trap entry wins over a divider completing in the same cycle.
                if (i_ma_exc) begin
                    ctrl           = CTRL_FLUSH_ALL;
                    div_kill       = 1'b1;
                    state_next     = TRAP_DRAIN;
                    drain_cnt_next = 4'd0;
                end else if (i_div_done) begin
                    state_next = RUN;
                end else if (div_cnt_reg == DIV_LIMIT) begin
                    div_timeout = 1'b1;
                    div_kill    = 1'b1;
                    state_next  = RUN;
                end else begin
                    ctrl = CTRL_STALL_ALL;
                end
            end
            TRAP_DRAIN: begin
                ctrl           = CTRL_FLUSH_ALL;
                drain_cnt_next = (drain_cnt_reg == 4'hf) ? drain_cnt_reg : drain_cnt_reg + 4'd1;
                if (drain_cnt_reg == DRAIN_LAST) begin
                    state_next = TRAP_TAKE;
                end
            end
            TRAP_TAKE: begin
                ctrl      = CTRL_FLUSH_ALL;
                trap_take = 1'b1;
                if (i_ma_exc) begin
                    state_next     = TRAP_DRAIN;
                    drain_cnt_next = 4'd0;
                end else begin
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase

        // Held in reset the pipe is kept empty and no pulses escape.
        if (!i_rst_n) begin
            ctrl        = CTRL_FLUSH_ALL;
            div_kill    = 1'b0;
            div_timeout = 1'b0;
            trap_take   = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_reg     <= RUN;
            div_cnt_reg   <= 6'd0;
            drain_cnt_reg <= 4'd0;
        end else begin
            state_reg     <= state_next;
            div_cnt_reg   <= div_cnt_next;
            drain_cnt_reg <= drain_cnt_next;
        end
    end

    assign o_fe_stall    = ctrl.fe_stall;
    assign o_de_stall    = ctrl.de_stall;
    assign o_ex_stall    = ctrl.ex_stall;
    assign o_fe_flush    = ctrl.fe_flush;
    assign o_de_flush    = ctrl.de_flush;
    assign o_ex_flush    = ctrl.ex_flush;
    assign o_div_kill    = div_kill;
    assign o_div_timeout = div_timeout;
    assign o_trap_take   = trap_take;

endmodule

// File: tb/tb_hazard_controller.sv
// Random-stimulus bench for hazard_controller against a cycle-level model
// that tracks "dividing for N cycles", "drain cycles left" and "trap due".
module tb_hazard_controller;

    localparam int DRAIN   = 2;
    localparam int DIV_MAX = 34;
    localparam int NCYC    = 6000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       de_valid, de_uses_rs1, de_uses_rs2;
    logic [4:0] de_rs1, de_rs2, ex_rd;
    logic       ex_valid, ex_is_load, ex_div_start, div_done, ex_redirect, ma_exc;
    logic       fe_stall, de_stall, ex_stall, fe_flush, de_flush, ex_flush;
    logic       div_kill, div_timeout, trap_take;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_controller #(
        .DRAIN_CYCLES   (DRAIN),
        .DIV_MAX_CYCLES (DIV_MAX)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_de_valid     (de_valid),
        .i_de_rs1       (de_rs1),
        .i_de_rs2       (de_rs2),
        .i_de_uses_rs1  (de_uses_rs1),
        .i_de_uses_rs2  (de_uses_rs2),
        .i_ex_valid     (ex_valid),
        .i_ex_rd        (ex_rd),
        .i_ex_is_load   (ex_is_load),
        .i_ex_div_start (ex_div_start),
        .i_div_done     (div_done),
        .i_ex_redirect  (ex_redirect),
        .i_ma_exc       (ma_exc),
        .o_fe_stall     (fe_stall),
        .o_de_stall     (de_stall),
        .o_ex_stall     (ex_stall),
        .o_fe_flush     (fe_flush),
        .o_de_flush     (de_flush),
        .o_ex_flush     (ex_flush),
        .o_div_kill     (div_kill),
        .o_div_timeout  (div_timeout),
        .o_trap_take    (trap_take)
    );

    // Order: fe/de/ex stall, fe/de/ex flush, kill, timeout, trap_take.
    task automatic check_val(input string tag, input logic [8:0] got, input logic [8:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got=%b exp=%b", tag, $time, got, exp);
        end
    endtask

    // Model state.
    bit m_div;
    int m_div_cnt;
    int m_drain_left;
    bit m_take_due;

    initial begin
        logic [8:0] exp_v, got_v;
        bit n_div, n_take, luse;
        int n_div_cnt, n_drain;
        int mode;
        string tag;

        m_div = 0; m_div_cnt = 0; m_drain_left = 0; m_take_due = 0;
        rst_n = 1'b0;
        de_valid = 0; de_uses_rs1 = 0; de_uses_rs2 = 0;
        de_rs1 = '0; de_rs2 = '0; ex_rd = '0;
        ex_valid = 0; ex_is_load = 0; ex_div_start = 0; div_done = 0;
        ex_redirect = 0; ma_exc = 0;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            mode = (cyc / 300) % 3;
            if (cyc < 3)
                rst_n = 1'b0;
            else
                rst_n = ($urandom_range(0, 249) != 0);
            de_valid     = ($urandom_range(0, 9) != 0);
            de_uses_rs1  = $urandom_range(0, 1);
            de_uses_rs2  = $urandom_range(0, 1);
            de_rs1       = 5'($urandom_range(0, 3));
            de_rs2       = 5'($urandom_range(0, 3));
            ex_valid     = ($urandom_range(0, 7) != 0);
            ex_rd        = 5'($urandom_range(0, 3));
            ex_is_load   = ($urandom_range(0, 2) == 0);
            ex_div_start = ($urandom_range(0, 11) == 0);
            ex_redirect  = ($urandom_range(0, 9) == 0);
            // Quiet phases let the watchdog expire; busy phases stress traps.
            div_done     = (mode == 0) ? 1'b0 : ($urandom_range(0, 14) == 0);
            ma_exc       = (mode == 2) ? ($urandom_range(0, 9) == 0)
                                       : ($urandom_range(0, 299) == 0);
            #1;

            luse = de_valid && ex_valid && ex_is_load && (ex_rd != 0) &&
                   ((de_uses_rs1 && de_rs1 == ex_rd) || (de_uses_rs2 && de_rs2 == ex_rd));

            exp_v = 9'b0;
            n_div = m_div; n_div_cnt = m_div_cnt; n_drain = m_drain_left; n_take = m_take_due;
            tag = "run";

            if (!rst_n) begin
                tag = "reset";
                exp_v = 9'b000_111_000;
                n_div = 0; n_div_cnt = 0; n_drain = 0; n_take = 0;
            end else if (m_take_due) begin
                tag = "trap_take";
                exp_v = 9'b000_111_001;
                n_take = 0;
                if (ma_exc) n_drain = DRAIN;
            end else if (m_drain_left > 0) begin
                tag = "drain";
                exp_v = 9'b000_111_000;
                n_drain = m_drain_left - 1;
                if (n_drain == 0) n_take = 1;
            end else if (m_div) begin
                tag = "div";
                n_div_cnt = m_div_cnt + 1;
                if (ma_exc) begin
                    exp_v = 9'b000_111_100;
                    n_div = 0; n_drain = DRAIN;
                end else if (div_done) begin
                    n_div = 0;
                end else if (m_div_cnt == DIV_MAX) begin
                    tag = "div_timeout";
                    exp_v = 9'b000_000_110;
                    n_div = 0;
                end else begin
                    exp_v = 9'b111_000_000;
                end
            end else begin
                if (ma_exc) begin
                    tag = "exc";
                    exp_v = {6'b000_111, ex_div_start, 2'b00};
                    n_drain = DRAIN;
                end else if (ex_redirect) begin
                    tag = "redirect";
                    exp_v = 9'b000_110_000;
                end else if (ex_div_start) begin
                    tag = "div_start";
                    exp_v = 9'b111_000_000;
                    n_div = 1; n_div_cnt = 1;
                end else if (luse) begin
                    tag = "load_use";
                    exp_v = 9'b110_001_000;
                end
            end

            got_v = {fe_stall, de_stall, ex_stall, fe_flush, de_flush, ex_flush,
                     div_kill, div_timeout, trap_take};
            check_val(tag, got_v, exp_v);

            @(posedge clk);
            m_div = n_div; m_div_cnt = n_div_cnt;
            m_drain_left = n_drain; m_take_due = n_take;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
